// File: rtl/rv32i_lsu.sv
// Load/store unit for the memory-access stage: drives a pipelined Wishbone-style data
// bus, stalls upstream while busy, and hands formatted results to writeback.
module rv32i_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_y,
    input  logic [31:0] i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic        i_opcode_load,
    input  logic        i_opcode_store,
    input  logic [4:0]  i_rd_addr,
    input  logic        i_wr_rd,
    input  logic        i_ce,
    output logic        o_stall,
    output logic [31:0] o_y,
    output logic [4:0]  o_rd_addr,
    output logic        o_wr_rd,
    output logic        o_ce,
    output logic        o_misaligned,
    output logic        o_bus_err,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_stall,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_data
);
    // state  | meaning
    // IDLE   | ready; non-memory and misaligned ops retire here in one cycle
    // REQ    | cyc+stb asserted, waiting for the slave to take the strobe
    // WAIT   | strobe taken, cyc held until ack or timeout
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    localparam logic [7:0] LP_TC = 8'(TIMEOUT - 1);

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_cnt;
    logic [1:0]  r_lo;
    logic [2:0]  r_f3;
    logic        r_load;
    logic [31:0] r_y;
    logic [4:0]  r_rd;
    logic        r_wr;

    logic        w_is_mem, w_misal, w_idle, w_accept, w_ack, w_tmo;
    logic [3:0]  w_sel;
    logic [31:0] w_sdata, w_lane, w_fmt;

    assign w_is_mem = i_opcode_load | i_opcode_store;
    assign w_misal  = (i_funct3[1] & (i_y[1:0] != 2'b00)) |
                      (~i_funct3[1] & i_funct3[0] & i_y[0]);
    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = w_idle & i_ce & w_is_mem & ~w_misal;
    assign o_stall  = ~w_idle | w_accept;

    // An ack in REQ only counts once the strobe is actually taken.
    assign w_ack = ((r_state == S_REQ) & ~i_wb_stall & i_wb_ack) |
                   ((r_state == S_WAIT) & i_wb_ack);
    assign w_tmo = ~w_idle & (r_cnt == LP_TC) & ~w_ack;

    always_comb begin
        w_sel   = 4'b1111;
        w_sdata = i_rs2;
        case (i_funct3[1:0])
            2'b00: begin
                w_sel   = 4'b0001 << i_y[1:0];
                w_sdata = {4{i_rs2[7:0]}};
            end
            2'b01: begin
                w_sel   = 4'b0011 << {i_y[1], 1'b0};
                w_sdata = {2{i_rs2[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_lane = i_wb_data >> {r_lo, 3'b000};
        w_fmt  = i_wb_data;
        case (r_f3)
            3'b000: w_fmt = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b001: w_fmt = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b100: w_fmt = {24'd0, w_lane[7:0]};
            3'b101: w_fmt = {16'd0, w_lane[15:0]};
            default: ;
        endcase
        if (!r_load) w_fmt = r_y;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_REQ;
            S_REQ:   if (w_ack || w_tmo) w_state_nxt = S_IDLE;
                     else if (!i_wb_stall) w_state_nxt = S_WAIT;
            S_WAIT:  if (w_ack || w_tmo) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 8'd0;
            r_lo         <= 2'd0;
            r_f3         <= 3'd0;
            r_load       <= 1'b0;
            r_y          <= 32'd0;
            r_rd         <= 5'd0;
            r_wr         <= 1'b0;
            o_y          <= 32'd0;
            o_rd_addr    <= 5'd0;
            o_wr_rd      <= 1'b0;
            o_ce         <= 1'b0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
            o_wb_cyc     <= 1'b0;
            o_wb_stb     <= 1'b0;
            o_wb_we      <= 1'b0;
            o_wb_addr    <= 32'd0;
            o_wb_data    <= 32'd0;
            o_wb_sel     <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            o_ce         <= 1'b0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
            if (w_idle) begin
                if (i_ce && !w_is_mem) begin
                    o_y       <= i_y;
                    o_rd_addr <= i_rd_addr;
                    o_wr_rd   <= i_wr_rd;
                    o_ce      <= 1'b1;
                end else if (i_ce && w_misal) begin
                    o_y          <= i_y;
                    o_rd_addr    <= i_rd_addr;
                    o_wr_rd      <= 1'b0;
                    o_ce         <= 1'b1;
                    o_misaligned <= 1'b1;
                end else if (w_accept) begin
                    o_wb_cyc  <= 1'b1;
                    o_wb_stb  <= 1'b1;
                    o_wb_we   <= i_opcode_store & ~i_opcode_load;
                    o_wb_addr <= {i_y[31:2], 2'b00};
                    o_wb_sel  <= w_sel;
                    o_wb_data <= w_sdata;
                    r_cnt     <= 8'd0;
                    r_lo      <= i_y[1:0];
                    r_f3      <= i_funct3;
                    r_load    <= i_opcode_load;
                    r_y       <= i_y;
                    r_rd      <= i_rd_addr;
                    r_wr      <= i_wr_rd;
                end
            end else begin
                r_cnt <= r_cnt + 8'd1;
                if (r_state == S_REQ && !i_wb_stall) o_wb_stb <= 1'b0;
                if (w_ack) begin
                    o_wb_cyc  <= 1'b0;
                    o_wb_stb  <= 1'b0;
                    o_y       <= w_fmt;
                    o_rd_addr <= r_rd;
                    o_wr_rd   <= r_wr;
                    o_ce      <= 1'b1;
                end else if (w_tmo) begin
                    o_wb_cyc  <= 1'b0;
                    o_wb_stb  <= 1'b0;
                    o_y       <= r_y;
                    o_rd_addr <= r_rd;
                    o_wr_rd   <= 1'b0;
                    o_ce      <= 1'b1;
                    o_bus_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rv32i_lsu.sv
// Randomized bench for rv32i_lsu: a bench-side slave drives bus timing and an
// arithmetic reference model predicts results, lanes and latency.
module tb_rv32i_lsu;
    localparam int TO = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] i_y, i_rs2, i_wb_data;
    logic [2:0]  i_funct3;
    logic        i_opcode_load, i_opcode_store, i_wr_rd, i_ce, i_wb_stall, i_wb_ack;
    logic [4:0]  i_rd_addr;
    logic        o_stall, o_wr_rd, o_ce, o_misaligned, o_bus_err;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [31:0] o_y, o_wb_addr, o_wb_data;
    logic [4:0]  o_rd_addr;
    logic [3:0]  o_wb_sel;

    int n_tests = 0;
    int n_fail  = 0;

    rv32i_lsu #(.TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_y(i_y), .i_rs2(i_rs2), .i_funct3(i_funct3),
        .i_opcode_load(i_opcode_load), .i_opcode_store(i_opcode_store),
        .i_rd_addr(i_rd_addr), .i_wr_rd(i_wr_rd), .i_ce(i_ce), .o_stall(o_stall),
        .o_y(o_y), .o_rd_addr(o_rd_addr), .o_wr_rd(o_wr_rd), .o_ce(o_ce),
        .o_misaligned(o_misaligned), .o_bus_err(o_bus_err), .o_wb_cyc(o_wb_cyc),
        .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
        .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel), .i_wb_stall(i_wb_stall),
        .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] d);
        logic [31:0] w;
        w = d >> (8 * a[1:0]);
        case (f3)
            3'd0: return w[7]  ? ((w & 32'hFF)   | 32'hFFFF_FF00) : (w & 32'hFF);
            3'd1: return w[15] ? ((w & 32'hFFFF) | 32'hFFFF_0000) : (w & 32'hFFFF);
            3'd4: return w & 32'hFF;
            3'd5: return w & 32'hFFFF;
            default: return d;
        endcase
    endfunction

    task automatic idle_cycle();
        i_ce       = 1'b0;
        i_wb_ack   = 1'($urandom_range(0, 1));
        i_wb_data  = $urandom;
        i_wb_stall = 1'b0;
        @(posedge i_clk); #1;
        check("no_ce_idle", {31'd0, o_ce}, 32'd0);
        check("no_cyc_idle", {31'd0, o_wb_cyc}, 32'd0);
        i_wb_ack = 1'b0;
    endtask

    task automatic issue(input logic [31:0] y, input logic [31:0] rs2, input logic [2:0] f3,
                         input logic ld, input logic st, input logic [4:0] rd, input logic wr,
                         input int nstall, input int ackdly, input bit noack,
                         input logic [31:0] rdata);
        bit   mem, mis, err, got;
        int   sz, ackc, expk, k;
        logic [31:0] exp_y;
        mem = ld | st;
        sz  = acc_size(f3);
        mis = mem && ((int'(y[1:0]) % sz) != 0);
        i_y = y; i_rs2 = rs2; i_funct3 = f3; i_opcode_load = ld; i_opcode_store = st;
        i_rd_addr = rd; i_wr_rd = wr; i_ce = 1'b1;
        #1;
        check("stall_accept", {31'd0, o_stall}, {31'd0, mem && !mis});
        @(posedge i_clk); #1;
        if (!mem || mis) begin
            check("ce_fast", {31'd0, o_ce}, 32'd1);
            check("y_fast", o_y, y);
            check("rd_fast", {27'd0, o_rd_addr}, {27'd0, rd});
            check("wr_fast", {31'd0, o_wr_rd}, {31'd0, wr && !mis});
            check("misal", {31'd0, o_misaligned}, {31'd0, mis});
            check("cyc_fast", {31'd0, o_wb_cyc}, 32'd0);
            check("stall_fast", {31'd0, o_stall}, 32'd0);
            idle_cycle();
            return;
        end
        i_ce = 1'b0;
        check("cyc_req", {31'd0, o_wb_cyc}, 32'd1);
        check("we", {31'd0, o_wb_we}, {31'd0, st && !ld});
        check("addr", o_wb_addr, y & 32'hFFFF_FFFC);
        check("sel", {28'd0, o_wb_sel}, ((32'd1 << sz) - 1) << y[1:0]);
        if (st && !ld)
            check("wdata", o_wb_data, (sz == 1) ? rs2[7:0] * 32'h0101_0101 :
                                      (sz == 2) ? rs2[15:0] * 32'h0001_0001 : rs2);
        ackc = nstall + 1 + ackdly;
        err  = noack || (ackc > TO);
        expk = err ? TO : ackc;
        k = 0; got = 0;
        while (!got && k < TO + 4) begin
            k++;
            check("stb", {31'd0, o_wb_stb}, {31'd0, k <= nstall + 1});
            check("stall_busy", {31'd0, o_stall}, 32'd1);
            i_wb_stall = (k <= nstall);
            i_wb_ack   = !noack && (k == ackc);
            i_wb_data  = i_wb_ack ? rdata : $urandom;
            @(posedge i_clk); #1;
            got = o_ce;
        end
        i_wb_ack = 1'b0; i_wb_stall = 1'b0;
        check("latency", k, expk);
        check("ce_mem", {31'd0, o_ce}, 32'd1);
        exp_y = err ? y : (ld ? ld_model(f3, y, rdata) : y);
        check("y_mem", o_y, exp_y);
        check("rd_mem", {27'd0, o_rd_addr}, {27'd0, rd});
        check("wr_mem", {31'd0, o_wr_rd}, {31'd0, wr && !err});
        check("bus_err", {31'd0, o_bus_err}, {31'd0, err});
        check("misal_mem", {31'd0, o_misaligned}, 32'd0);
        check("cyc_end", {30'd0, o_wb_cyc, o_wb_stb}, 32'd0);
        check("stall_end", {31'd0, o_stall}, 32'd0);
        idle_cycle();
    endtask

    initial begin
        int f3s[5] = '{0, 1, 2, 4, 5};
        int pick, k;
        bit ld, st;
        logic [31:0] a;
        i_rst_n = 1'b0; i_ce = 1'b0; i_y = '0; i_rs2 = '0; i_funct3 = '0;
        i_opcode_load = 1'b0; i_opcode_store = 1'b0; i_rd_addr = '0; i_wr_rd = 1'b0;
        i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_data = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_outs", {o_ce, o_misaligned, o_bus_err, o_wb_cyc, o_wb_stb, o_wb_we, o_wr_rd,
                           o_stall, o_wb_sel}, 32'd0);
        check("rst_y", o_y, 32'd0);
        i_rst_n = 1'b1;

        issue(32'h100, 0, 3'd2, 1, 0, 5'd3, 1, 0, 1, 0, 32'hDEADBEEF);
        issue(32'h103, 0, 3'd0, 1, 0, 5'd4, 1, 1, 0, 0, 32'h80123456);
        issue(32'h103, 0, 3'd4, 1, 0, 5'd4, 1, 0, 2, 0, 32'h80123456);
        issue(32'h202, 32'h1234, 3'd1, 0, 1, 5'd0, 0, 0, 1, 0, 0);
        issue(32'h101, 0, 3'd2, 1, 0, 5'd5, 1, 0, 0, 0, 0);
        issue(32'h300, 0, 3'd2, 1, 0, 5'd6, 1, 0, 0, 1, 0);
        issue(32'h12345678, 0, 3'd0, 0, 0, 5'd7, 1, 0, 0, 0, 0);

        // reset while in WAIT, then a stray ack must not retire anything
        i_y = 32'h400; i_funct3 = 3'd2; i_opcode_load = 1; i_opcode_store = 0; i_ce = 1;
        @(posedge i_clk); #1;
        i_ce = 1'b0;
        @(posedge i_clk); #1;
        check("wait_cyc", {31'd0, o_wb_cyc}, 32'd1);
        i_rst_n = 1'b0;
        @(posedge i_clk); #1;
        check("rst_mid", {o_ce, o_wb_cyc, o_wb_stb, o_wr_rd, o_stall, o_bus_err}, 32'd0);
        check("rst_mid_y", o_y, 32'd0);
        i_rst_n = 1'b1; i_wb_ack = 1'b1; i_wb_data = 32'hCAFEF00D;
        @(posedge i_clk); #1;
        check("ack_ignored", {31'd0, o_ce}, 32'd0);
        i_wb_ack = 1'b0;

        for (int n = 0; n < 200; n++) begin
            pick = $urandom_range(0, 9);
            ld = (pick < 5); st = (pick >= 5 && pick < 8);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            k = ld ? f3s[$urandom_range(0, 4)] : $urandom_range(0, 2);
            issue(a, $urandom, 3'(k), ld, st, 5'($urandom), 1'($urandom),
                  $urandom_range(0, 2), $urandom_range(0, 2), ($urandom_range(0, 9) == 0),
                  $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
